// File: rtl/udp_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter for the shared UDP egress stream.
// Grants hold until tlast. Runaway packets are truncated and their tail is discarded.
module udp_tx_pkt_arbiter #(
  parameter int NUM       = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BEATS = 1518,
  parameter int CNT_W     = 16
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NUM-1:0]         en_mask,
  input  logic [NUM-1:0]         s_tvalid,
  input  logic [NUM*DSIZE-1:0]   s_tdata,
  input  logic [NUM-1:0]         s_tlast,
  output logic [NUM-1:0]         s_tready,
  output logic                   m_tvalid,
  output logic [DSIZE-1:0]       m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [$clog2(NUM)-1:0] grant_idx,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic                   trunc_pulse,
  output logic [CNT_W-1:0]       trunc_cnt
);

  localparam int IW = $clog2(NUM);
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    hi_win, lo_win;
  logic             hi_found, lo_found;
  logic [BW-1:0]    beat_cnt;
  logic [NUM-1:0]   req;
  logic             any_req;
  logic             force_last;
  logic             sel_valid, sel_last;
  logic [DSIZE-1:0] sel_data;
  logic             beat, end_beat, trunc_beat, drop_end;

  assign req        = s_tvalid & en_mask;
  assign any_req    = |req;
  assign force_last = (beat_cnt == BW'(MAX_BEATS - 1));

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DSIZE +: DSIZE];
      end
    end
  end

  // Rotating priority: first requester above last_grant, else lowest.
  always_comb begin
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (req[i] && !hi_found && (IW'(i) > last_grant)) begin
        hi_win   = IW'(i);
        hi_found = 1'b1;
      end
      if (req[i] && !lo_found) begin
        lo_win   = IW'(i);
        lo_found = 1'b1;
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  assign beat       = (state_q == BUSY) & sel_valid & m_tready;
  assign end_beat   = beat & sel_last;
  assign trunc_beat = beat & ~sel_last & force_last;
  assign drop_end   = (state_q == DROP) & sel_valid & sel_last;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = BUSY;
      BUSY: begin
        if (end_beat)        state_d = IDLE;
        else if (trunc_beat) state_d = DROP;
      end
      DROP: if (drop_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      BUSY: begin
        busy     = 1'b1;
        m_tvalid = sel_valid;
        m_tdata  = sel_data;
        m_tlast  = sel_last | force_last;
        for (int i = 0; i < NUM; i++)
          if (grant_idx == IW'(i)) s_tready[i] = m_tready;
      end
      DROP: begin
        busy = 1'b1;
        for (int i = 0; i < NUM; i++)
          if (grant_idx == IW'(i)) s_tready[i] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx   <= '0;
      last_grant  <= IW'(NUM - 1);
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      trunc_cnt   <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= trunc_beat;
      if (state_q == IDLE && any_req) begin
        grant_idx <= winner;
        beat_cnt  <= '0;
      end
      if (beat && !sel_last && !force_last)
        beat_cnt <= beat_cnt + BW'(1);
      if (end_beat || trunc_beat)
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (end_beat || drop_end)
        last_grant <= grant_idx;
      // Saturate so a flood of runaways never reads as zero.
      if (trunc_beat && (trunc_cnt != '1))
        trunc_cnt <= trunc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_udp_tx_pkt_arbiter.sv
// Scoreboard bench for udp_tx_pkt_arbiter.
// Packet-level reference model predicts the egress beat stream.
module tb_udp_tx_pkt_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int MAXB  = 8;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic [NUM-1:0]   en_mask;
  logic [NUM-1:0]   s_tvalid;
  logic [NUM*8-1:0] s_tdata;
  logic [NUM-1:0]   s_tlast;
  logic [NUM-1:0]   s_tready;
  logic             m_tvalid;
  logic [7:0]       m_tdata;
  logic             m_tlast;
  logic             m_tready;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [15:0]      pkt_cnt;
  logic             trunc_pulse;
  logic [15:0]      trunc_cnt;

  always #5 clock = ~clock;

  udp_tx_pkt_arbiter #(
    .NUM(NUM), .DSIZE(DSIZE), .MAX_BEATS(MAXB), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .rst_n(rst_n), .en_mask(en_mask),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tready(m_tready), .grant_idx(grant_idx),
    .busy(busy), .pkt_cnt(pkt_cnt), .trunc_pulse(trunc_pulse),
    .trunc_cnt(trunc_cnt)
  );

  typedef struct packed {
    logic [1:0] src;
    logic       last;
    logic [7:0] data;
  } beat_t;

  int tests = 0;
  int fails = 0;

  logic [8:0]     srcq [NUM][$];
  logic [7:0]     mdat [NUM][$];
  int             mlen [NUM][$];
  beat_t          expq [$];
  logic [NUM-1:0] first_b;
  logic [NUM-1:0] bubble;
  int             rdy_mode;
  bit             bub_en;
  int             mlast, mpkts, mtrunc;
  int             pulses, pulse_base;

  task automatic chk(input string n, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, act, want);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NUM; i++) begin
      if (srcq[i].size() > 0 && !bubble[i]) begin
        h = srcq[i][0];
        s_tvalid[i]         = 1'b1;
        s_tlast[i]          = h[8];
        s_tdata[i*8 +: 8]   = h[7:0];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tlast[i]          = 1'b0;
        s_tdata[i*8 +: 8]   = 8'($urandom);
      end
    end
  endtask

  task automatic cycle();
    logic [NUM-1:0] fire;
    logic [8:0]     h;
    @(negedge clock);
    fire = s_tvalid & s_tready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM; i++) begin
      if (fire[i]) begin
        h = srcq[i].pop_front();
        first_b[i] = h[8];
      end
    end
    for (int i = 0; i < NUM; i++)
      bubble[i] = bub_en && !first_b[i] && ($urandom_range(0, 3) == 0);
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
    drive();
  endtask

  task automatic add_pkt(input int s, input int len, input int base);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = (base >= 0) ? 8'(base + k) : 8'($urandom);
      srcq[s].push_back({(k == len - 1), d});
      mdat[s].push_back(d);
    end
    mlen[s].push_back(len);
  endtask

  // Round-robin at packet granularity over whatever is pending.
  task automatic plan();
    int    s, len;
    beat_t e;
    forever begin
      s = -1;
      for (int j = 1; j <= NUM; j++) begin
        int c;
        c = (mlast + j) % NUM;
        if (s < 0 && en_mask[c] && mlen[c].size() > 0) s = c;
      end
      if (s < 0) break;
      len = mlen[s].pop_front();
      for (int k = 0; k < len; k++) begin
        e.data = mdat[s].pop_front();
        e.src  = 2'(s);
        e.last = (k == len - 1) || (k == MAXB - 1);
        if (k < MAXB) expq.push_back(e);
      end
      mpkts++;
      if (len > MAXB) mtrunc++;
      mlast = s;
    end
  endtask

  task automatic drain(input string n, output int cyc);
    cyc = 0;
    while ((expq.size() > 0 || busy) && cyc < 2000) begin
      cycle();
      cyc++;
    end
    chk({n, "_timeout"}, int'(cyc < 2000), 1);
    chk({n, "_left"}, expq.size(), 0);
    chk({n, "_pkt_cnt"}, int'(pkt_cnt), mpkts & 16'hffff);
    chk({n, "_trunc_cnt"}, int'(trunc_cnt), mtrunc);
    chk({n, "_pulses"}, pulses - pulse_base, mtrunc);
  endtask

  task automatic monitor();
    beat_t e;
    int    want_r;
    forever begin
      @(negedge clock);
      if (rst_n) begin
        if (trunc_pulse) pulses++;
        if (!busy)
          chk("idle_tready", int'(s_tready), 0);
        else if (m_tvalid) begin
          want_r = m_tready ? (1 << int'(grant_idx)) : 0;
          chk("busy_tready", int'(s_tready), want_r);
        end
        if (m_tvalid && m_tready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got src %0d data 0x%0h, want none",
                     grant_idx, m_tdata);
          end else begin
            e = expq.pop_front();
            chk("beat", int'({grant_idx, m_tlast, m_tdata}), int'(e));
          end
        end
      end
    end
  endtask

  task automatic main_seq();
    int cyc, n1;
    en_mask  = '0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    first_b  = '1;
    bubble   = '0;
    rdy_mode = 0;
    bub_en   = 0;
    mlast    = NUM - 1;
    mpkts    = 0;
    mtrunc   = 0;
    pulses   = 0;
    pulse_base = 0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_s_tready", int'(s_tready), 0);
    chk("rst_grant", int'(grant_idx), 0);
    chk("rst_pkt_cnt", int'(pkt_cnt), 0);
    chk("rst_trunc_cnt", int'(trunc_cnt), 0);
    chk("rst_pulse", int'(trunc_pulse), 0);
    chk("rst_m_tdata", int'(m_tdata), 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    en_mask  = 4'hf;
    m_tready = 1'b1;
    for (int s = 0; s < NUM; s++) add_pkt(s, 3, 8'h40 + s * 8'h10);
    plan();
    drive();
    drain("p1", cyc);
    chk("p1_cycles", cyc, 16);
    chk("p1_grant", int'(grant_idx), 3);

    rdy_mode = 1;
    add_pkt(2, 5, 8'h10);
    plan();
    drive();
    drain("p2", cyc);

    rdy_mode = 2;
    bub_en   = 1;
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, $urandom_range(1, 6), -1);
      add_pkt(1, $urandom_range(1, 6), -1);
    end
    plan();
    drive();
    drain("p3a", cyc);

    en_mask = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, $urandom_range(1, 6), -1);
      add_pkt(1, $urandom_range(1, 6), -1);
      add_pkt(3, $urandom_range(1, 6), -1);
    end
    n1 = srcq[1].size();
    plan();
    drive();
    drain("p3b", cyc);
    chk("p3b_src1_held", srcq[1].size(), n1);

    en_mask = 4'hf;
    plan();
    drive();
    drain("p3c", cyc);

    add_pkt(3, 12, 8'h80);
    plan();
    drive();
    repeat (3) cycle();
    en_mask = 4'b0111;
    drain("p4", cyc);
    chk("p4_trunc_cnt", int'(trunc_cnt), 1);
    en_mask = 4'hf;

    add_pkt(0, 7, 8'h20);
    add_pkt(0, 8, 8'h30);
    plan();
    drive();
    drain("p5", cyc);
    chk("p5_trunc_cnt", int'(trunc_cnt), 1);

    for (int r = 0; r < 25; r++) begin
      en_mask  = 4'($urandom_range(0, 15));
      bub_en   = ($urandom_range(0, 1) == 1);
      rdy_mode = 2;
      for (int k = 0; k < $urandom_range(1, 6); k++)
        add_pkt($urandom_range(0, NUM - 1), $urandom_range(1, 12), -1);
      plan();
      drive();
      drain("rnd", cyc);
    end
    en_mask = 4'hf;
    plan();
    drive();
    drain("flush", cyc);

    rdy_mode = 0;
    bub_en   = 0;
    bubble   = '0;
    add_pkt(2, 4, 8'h60);
    plan();
    drive();
    cyc = 0;
    while (expq.size() > 3 && cyc < 100) begin
      cycle();
      cyc++;
    end
    chk("p6_reach_beat2", expq.size(), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p6_m_tvalid", int'(m_tvalid), 0);
    chk("p6_busy", int'(busy), 0);
    chk("p6_s_tready", int'(s_tready), 0);
    chk("p6_grant", int'(grant_idx), 0);
    chk("p6_pkt_cnt", int'(pkt_cnt), 0);
    chk("p6_trunc_cnt", int'(trunc_cnt), 0);
    chk("p6_m_tdata", int'(m_tdata), 0);
    for (int i = 0; i < NUM; i++) begin
      srcq[i].delete();
      mdat[i].delete();
      mlen[i].delete();
    end
    expq.delete();
    mlast      = NUM - 1;
    mpkts      = 0;
    mtrunc     = 0;
    pulse_base = pulses;
    first_b    = '1;
    add_pkt(1, 2, 8'h70);
    add_pkt(0, 2, 8'h78);
    plan();
    drive();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    drain("p6", cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
  end

endmodule

// File: doc/udp_tx_pkt_arbiter.md
Name: udp_tx_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single outbound UDP AXI-stream among NUM requesters, e.g. parse-field responders and table readback.
- The grant is held from the first beat to the tlast beat, so packets never interleave.
- A beat-length watchdog truncates runaway packets and discards their remainder, protecting the Ethernet egress path.
- Sits directly in front of the module's egress AXI-stream master port.

Parameters:
NUM, 4, number of requesting streams (2..8)
DSIZE, 8, tdata width per stream in bits
MAX_BEATS, 1518, maximum beats per packet before forced truncation
CNT_W, 16, width of packet and error counters

Ports:
clock  input  1  single clock for all logic
rst_n  input  1  asynchronous active-low reset
en_mask  input  NUM  per-source enable; a disabled source is never granted
s_tvalid  input  NUM  per-source valid
s_tdata  input  NUM*DSIZE  source i data occupies bits [i*DSIZE +: DSIZE]
s_tlast  input  NUM  per-source last beat
s_tready  output  NUM  per-source ready
m_tvalid  output  1  egress valid
m_tdata  output  DSIZE  egress data
m_tlast  output  1  egress last beat
m_tready  input  1  egress ready
grant_idx  output  $clog2(NUM)  index of the current or last granted source
busy  output  1  high while a packet is owned (BUSY or DROP)
pkt_cnt  output  CNT_W  packets completed on egress, wraps
trunc_pulse  output  1  one-cycle pulse when a truncation occurs
trunc_cnt  output  CNT_W  truncation events, saturating

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low; there are no other clocks.
- Reset values:
  - state = IDLE
  - grant_idx = 0
  - last_grant = NUM-1, so source 0 wins first
  - m_tvalid, m_tlast, busy, trunc_pulse = 0
  - m_tdata = 0
  - s_tready = 0
  - pkt_cnt, trunc_cnt, beat counter = 0
- IDLE:
  - All s_tready = 0 and m_tvalid = 0.
  - req = s_tvalid & en_mask.
  - If req != 0, the winner is the first set bit searching upward from last_grant+1, wrapping modulo NUM.
  - grant_idx <= winner, beat counter <= 0, state <= BUSY.
  - This costs one bubble cycle per packet.
- BUSY (pass-through):
  - The egress signals are combinational from the granted source: m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], m_tlast = s_tlast[g] OR force_last.
  - s_tready[g] = m_tready; every other s_tready is 0.
  - A beat is m_tvalid & m_tready. Each beat increments the beat counter.
  - force_last is high when the beat counter == MAX_BEATS-1.
  - Beat with s_tlast (normal end):
    - pkt_cnt += 1 (wrapping), last_grant <= g, state <= IDLE.
  - Beat with force_last and no s_tlast (truncation):
    - m_tlast is driven high on that beat and pkt_cnt += 1.
    - trunc_pulse = 1 on the next cycle; trunc_cnt += 1, saturating at all-ones.
    - state <= DROP.
  - If s_tlast and force_last coincide, the beat counts as a normal end with no truncation.
- DROP (discard remainder):
  - m_tvalid = 0 and s_tready[g] = 1.
  - Source beats are consumed and discarded.
  - On a beat with s_tvalid[g] & s_tlast[g]: last_grant <= g, state <= IDLE.
- en_mask:
  - Sampled only in IDLE.
  - Deasserting the granted source's enable mid-packet has no effect until the packet ends.
- Source behaviour: a source dropping s_tvalid mid-packet stalls egress (m_tvalid low). The grant is held and there is no timeout.
- Empty request: if all req bits are 0, stay in IDLE with no change to last_grant.
- busy = 1 in BUSY and DROP.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is abandoned. Downstream is responsible for recovery.
- Latency: 0 cycles data path once granted; 1 cycle from request to first possible egress beat.

Test Plan:
1. All 4 sources each offer one 3-beat packet simultaneously after reset, m_tready=1 -> egress order 0,1,2,3, each packet separated by one idle cycle, pkt_cnt=4, grant_idx=3 at the end.
2. Backpressure: source 2 alone sends 5 beats 0x10..0x14 while m_tready toggles 1,0 -> all 5 beats appear in order; s_tready[2] mirrors m_tready; other s_tready stay 0.
3. Fairness: sources 0 and 1 continuously request with last_grant=0 -> grants alternate 1,0,1,0; with en_mask=4'b1101, source 1 is never granted.
4. Truncation: MAX_BEATS=8, source 3 sends a 12-beat packet -> 8 egress beats with m_tlast on beat 8, remaining 4 beats consumed with m_tvalid=0, trunc_pulse once, trunc_cnt=1, pkt_cnt +1.
5. Boundary: a 7-beat packet and then a packet of exactly 8 beats (tlast on beat 8) with MAX_BEATS=8 -> no truncation for either; trunc_cnt=0.
6. Reset asserted mid-beat 2 of a 4-beat packet -> outputs return to reset values asynchronously; after release, source 0 wins first if requesting.
